seq_normalizer32: RTL and testbench



---
 rtl/seq_normalizer32_pkg.sv | 38 +++
 rtl/seq_normalizer32_norm_step.sv | 49 ++++
 rtl/seq_normalizer32.sv | 130 +++++++++++++
 tb/tb_seq_normalizer32.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/seq_normalizer32_pkg.sv
// ---------------------------------------------------------------------------
// seq_normalizer32_pkg
//   Shared definitions for the multi-cycle 32-bit normalizer:
//   - data/count widths
//   - FSM state encodings (IDLE / RUN / FIN)
//   - the binary-search step table (16, 8, 4, 2, 1)
// ---------------------------------------------------------------------------
package seq_normalizer32_pkg;

  localparam int NORM_WIDTH = 32;
  localparam int NORM_CNT_W = 6;

  typedef logic [NORM_WIDTH-1:0] word_t;
  typedef logic [NORM_CNT_W-1:0] count_t;

  // FSM state encodings
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_FIN  = 2'd2;

  // Step index of the final (k = 1) step; the FSM leaves RUN on this step.
  localparam logic [2:0] STEP_LAST = 3'd4;

  // Count reported for an all-zero operand.
  localparam count_t CNT_ZERO_OPERAND = 6'd32;

  // Step table: index 0..4 selects shift amount 16, 8, 4, 2, 1.
  function automatic count_t step_amount(input logic [2:0] step);
    case (step)
      3'd0:    step_amount = 6'd16;
      3'd1:    step_amount = 6'd8;
      3'd2:    step_amount = 6'd4;
      3'd3:    step_amount = 6'd2;
      default: step_amount = 6'd1;
    endcase
  endfunction

endpackage

// File: rtl/seq_normalizer32_norm_step.sv
// ---------------------------------------------------------------------------
// seq_normalizer32_norm_step
//   One combinational normalization stage. Tests whether the k bits at the
//   outgoing end of the word are all zero and, if so, shifts them out.
//
//   Ports:
//     w_in   [31:0] in   current working word
//     k_sel  [2:0]  in   step index (0..4 -> k = 16, 8, 4, 2, 1)
//     dir           in   0 = shift left (leading zeros), 1 = shift right
//     w_out  [31:0] out  w_in shifted by k when take, else w_in
//     take          out  the k tested bits were all zero
//     inc    [5:0]  out  k, the count increment applied when take is set
// ---------------------------------------------------------------------------
module seq_normalizer32_norm_step
  import seq_normalizer32_pkg::*;
(
  input  word_t       w_in,
  input  logic [2:0]  k_sel,
  input  logic        dir,
  output word_t       w_out,
  output logic        take,
  output count_t      inc
);

  localparam word_t ALL_ONES = {NORM_WIDTH{1'b1}};

  count_t k;
  word_t  test_mask;

  always_comb begin
    k = step_amount(k_sel);
    // Left mode tests the top k bits, right mode the bottom k bits.
    if (dir) begin
      test_mask = ~(ALL_ONES << k);
    end else begin
      test_mask = ~(ALL_ONES >> k);
    end
    take = ((w_in & test_mask) == '0);
    if (!take) begin
      w_out = w_in;
    end else if (dir) begin
      w_out = w_in >> k;
    end else begin
      w_out = w_in << k;
    end
    inc = k;
  end

endmodule

// File: rtl/seq_normalizer32.sv
// ---------------------------------------------------------------------------
// seq_normalizer32
//   Multi-cycle 32-bit normalizer. Shifts the operand until bit 31 (left
//   mode) or bit 0 (right mode) is set and reports the shift count, using a
//   five-step binary search (16, 8, 4, 2, 1). Latency is fixed: DONE pulses
//   five clock edges after the edge that accepts START.
//
//   Parameters:
//     WIDTH  data width (only 32 supported)
//     CNT_W  count width (must hold 32)
//
//   Ports:
//     CLK          in   clock, rising edge
//     RST          in   synchronous reset, active-high
//     START        in   request, sampled when not busy (IDLE or FIN)
//     DIR          in   0 = leading zeros, 1 = trailing zeros
//     D     [31:0] in   operand
//     Y     [31:0] out  normalized result (valid from DONE to next START)
//     CNT   [5:0]  out  shift count 0..32
//     ZERO         out  operand was zero
//     BUSY         out  operation in progress (RUN)
//     DONE         out  one-cycle completion pulse (FIN)
// ---------------------------------------------------------------------------
module seq_normalizer32
  import seq_normalizer32_pkg::*;
#(
  parameter int WIDTH = NORM_WIDTH,
  parameter int CNT_W = NORM_CNT_W
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic             DIR,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Y,
  output logic [CNT_W-1:0] CNT,
  output logic             ZERO,
  output logic             BUSY,
  output logic             DONE
);

  logic [1:0] state_q, state_d;
  word_t      w_q,     w_d;
  logic       dir_q,   dir_d;
  count_t     cnt_q,   cnt_d;
  logic       zero_q,  zero_d;
  logic [2:0] step_q,  step_d;

  word_t      step_w;
  logic       step_take;
  count_t     step_inc;

  // A single stage, reused on each RUN cycle with the step counter as k.
  seq_normalizer32_norm_step u_step (
    .w_in  (w_q),
    .k_sel (step_q),
    .dir   (dir_q),
    .w_out (step_w),
    .take  (step_take),
    .inc   (step_inc)
  );

  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    dir_d   = dir_q;
    cnt_d   = cnt_q;
    zero_d  = zero_q;
    step_d  = step_q;

    case (state_q)
      ST_IDLE, ST_FIN: begin
        if (START) begin
          w_d     = D;
          dir_d   = DIR;
          cnt_d   = '0;
          zero_d  = (D == '0);
          step_d  = '0;
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_RUN: begin
        if (step_take) begin
          w_d   = step_w;
          cnt_d = cnt_q + step_inc;
        end
        step_d = step_q + 3'd1;
        if (step_q == STEP_LAST) begin
          state_d = ST_FIN;
          // A zero operand takes every step and would sum to 31; report 32.
          if (zero_q) begin
            cnt_d = CNT_ZERO_OPERAND;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      w_q     <= '0;
      dir_q   <= 1'b0;
      cnt_q   <= '0;
      zero_q  <= 1'b0;
      step_q  <= '0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      dir_q   <= dir_d;
      cnt_q   <= cnt_d;
      zero_q  <= zero_d;
      step_q  <= step_d;
    end
  end

  assign Y    = w_q;
  assign CNT  = cnt_q;
  assign ZERO = zero_q;
  assign BUSY = (state_q == ST_RUN);
  assign DONE = (state_q == ST_FIN);

endmodule

// File: tb/tb_seq_normalizer32.sv
// ---------------------------------------------------------------------------
// tb_seq_normalizer32
//   Self-checking bench: a transaction-level model (accept -> result after
//   five edges) is compared against the DUT every cycle, plus directed
//   vectors with hand-computed expectations.
// ---------------------------------------------------------------------------
module tb_seq_normalizer32;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        START = 1'b0;
  logic        DIR = 1'b0;
  logic [31:0] D = '0;
  logic [31:0] Y;
  logic [5:0]  CNT;
  logic        ZERO;
  logic        BUSY;
  logic        DONE;

  int checks = 0;
  int errors = 0;
  int done_count = 0;

  seq_normalizer32 dut (
    .CLK   (CLK),
    .RST   (RST),
    .START (START),
    .DIR   (DIR),
    .D     (D),
    .Y     (Y),
    .CNT   (CNT),
    .ZERO  (ZERO),
    .BUSY  (BUSY),
    .DONE  (DONE)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [5:0] ref_cnt(input logic [31:0] d, input logic dir);
    if (d == 32'h0) return 6'd32;
    for (int i = 0; i < 32; i++) begin
      if (dir ? d[i] : d[31-i]) return 6'(i);
    end
    return 6'd0;
  endfunction

  function automatic logic [31:0] ref_y(input logic [31:0] d, input logic dir);
    logic [5:0] c;
    c = ref_cnt(d, dir);
    if (c == 6'd32) return 32'h0;
    return dir ? (d >> c) : (d << c);
  endfunction

  bit          m_init  = 1'b0;
  bit          m_run   = 1'b0;
  bit          m_fin   = 1'b0;
  bit          m_valid = 1'b0;
  int          m_rem   = 0;
  logic [31:0] m_y     = '0;
  logic [5:0]  m_cnt   = '0;
  logic        m_zero  = 1'b0;

  always @(posedge CLK) begin
    if (RST) begin
      m_init  <= 1'b1;
      m_run   <= 1'b0;
      m_fin   <= 1'b0;
      m_valid <= 1'b1;
      m_rem   <= 0;
      m_y     <= '0;
      m_cnt   <= '0;
      m_zero  <= 1'b0;
    end else if (m_run) begin
      m_rem <= m_rem - 1;
      if (m_rem == 1) begin
        m_run   <= 1'b0;
        m_fin   <= 1'b1;
        m_valid <= 1'b1;
      end
    end else begin
      m_fin <= 1'b0;
      if (START) begin
        m_run   <= 1'b1;
        m_rem   <= 5;
        m_valid <= 1'b0;
        m_y     <= ref_y(D, DIR);
        m_cnt   <= ref_cnt(D, DIR);
        m_zero  <= (D == 32'h0);
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge CLK) begin
    if (m_init) begin
      chk("busy", 32'(BUSY), 32'(m_run));
      chk("done", 32'(DONE), 32'(m_fin));
      if (m_valid) begin
        chk("y", Y, m_y);
        chk("cnt", 32'(CNT), 32'(m_cnt));
        chk("zero", 32'(ZERO), 32'(m_zero));
      end
      if (DONE) begin
        done_count++;
        $display("done y=%h cnt=%0d zero=%0d", Y, CNT, ZERO);
      end
    end
  end

  // ---------------- directed helpers ----------------
  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (!DONE && n < 12) begin
      @(negedge CLK);
      n++;
    end
    chk({name, "_latency"}, 32'(n), 32'd5);
  endtask

  task automatic check_result(input string name, input logic [31:0] ey,
                              input logic [5:0] ec, input logic ez);
    chk({name, "_y"}, Y, ey);
    chk({name, "_cnt"}, 32'(CNT), 32'(ec));
    chk({name, "_zero"}, 32'(ZERO), 32'(ez));
  endtask

  // Called at a negedge with the DUT in IDLE or FIN.
  task automatic run_op(input string name, input logic [31:0] d, input logic dir,
                        input logic [31:0] ey, input logic [5:0] ec, input logic ez);
    START = 1'b1;
    D     = d;
    DIR   = dir;
    @(negedge CLK);
    START = 1'b0;
    wait_done(name);
    check_result(name, ey, ec, ez);
    $display("op %s d=%h dir=%0d y=%h cnt=%0d zero=%0d", name, d, dir, Y, CNT, ZERO);
  endtask

  function automatic logic [31:0] shaped_operand();
    logic [31:0] r;
    int          sh;
    r  = $urandom;
    sh = $urandom_range(0, 31);
    case ($urandom_range(0, 3))
      0:       return r >> sh;
      1:       return r << sh;
      2:       return 32'h1 << sh;
      default: return ($urandom_range(0, 3) == 0) ? 32'h0 : r;
    endcase
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    check_result("reset", 32'h0, 6'd0, 1'b0);
    chk("reset_busy", 32'(BUSY), 32'd0);
    chk("reset_done", 32'(DONE), 32'd0);
    @(negedge CLK);

    run_op("lz_one",  32'h0000_0001, 1'b0, 32'h8000_0000, 6'd31, 1'b0);
    @(negedge CLK);
    run_op("lz_f0",   32'h00F0_0000, 1'b0, 32'hF000_0000, 6'd8,  1'b0);
    run_op("lz_msb",  32'h8000_0000, 1'b0, 32'h8000_0000, 6'd0,  1'b0);
    run_op("tz_f00",  32'h0000_0F00, 1'b1, 32'h0000_000F, 6'd8,  1'b0);
    run_op("tz_msb",  32'h8000_0000, 1'b1, 32'h0000_0001, 6'd31, 1'b0);
    run_op("lz_zero", 32'h0000_0000, 1'b0, 32'h0000_0000, 6'd32, 1'b1);
    run_op("tz_zero", 32'h0000_0000, 1'b1, 32'h0000_0000, 6'd32, 1'b1);
    run_op("tz_lsb",  32'h1234_5679, 1'b1, 32'h1234_5679, 6'd0,  1'b0);
    @(negedge CLK);

    // START held through RUN with D changing: first result unaffected,
    // then START in the FIN cycle is accepted back-to-back.
    START = 1'b1;
    D     = 32'h0000_0001;
    DIR   = 1'b0;
    @(negedge CLK);
    D = 32'hFFFF_FFFF;
    wait_done("held1");
    check_result("held1", 32'h8000_0000, 6'd31, 1'b0);
    $display("op held1 d=00000001 dir=0 y=%h cnt=%0d", Y, CNT);
    @(negedge CLK);
    START = 1'b0;
    wait_done("held2");
    check_result("held2", 32'hFFFF_FFFF, 6'd0, 1'b0);
    $display("op held2 d=ffffffff dir=0 y=%h cnt=%0d", Y, CNT);
    @(negedge CLK);

    // Reset sampled on E3 of an operation aborts it.
    START = 1'b1;
    D     = 32'h0001_0000;
    DIR   = 1'b0;
    @(negedge CLK);
    START = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    check_result("abort", 32'h0, 6'd0, 1'b0);
    chk("abort_busy", 32'(BUSY), 32'd0);
    chk("abort_done", 32'(DONE), 32'd0);
    $display("op abort y=%h cnt=%0d busy=%0d done=%0d", Y, CNT, BUSY, DONE);
    repeat (6) @(negedge CLK);
    run_op("after_abort", 32'h0001_0000, 1'b0, 32'h8000_0000, 6'd15, 1'b0);
    @(negedge CLK);

    // Randomized traffic, checked cycle by cycle against the model.
    for (int i = 0; i < 4000; i++) begin
      START = ($urandom_range(0, 2) == 0);
      DIR   = 1'($urandom_range(0, 1));
      D     = shaped_operand();
      RST   = ($urandom_range(0, 199) == 0);
      @(negedge CLK);
    end
    START = 1'b0;
    RST   = 1'b0;
    repeat (8) @(negedge CLK);
    chk("random_done_seen", 32'(done_count > 100), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
